// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver.
//   rx -> 2-FF synchroniser -> start-bit validation -> mid-bit sampling of
//   DATA_BITS (LSB first) -> optional parity -> STOP_BITS stop checks.
//   Each received word is delivered with a one-cycle valid pulse. The
//   frame_err/parity_err flags are meaningful only while valid is high.
// Optional feature: define UART_RX_PARITY_EN to add the parity bit/check.
//   Without it there is no PARITY state, parity_err is tied low and
//   PARITY_ODD is ignored.
module uart_rx_param #(
    parameter int DATA_BITS    = 8,   // 5..9
    parameter int CLKS_PER_BIT = 16,  // even, >= 4
    parameter int STOP_BITS    = 1,   // 1 or 2
    parameter int PARITY_ODD   = 0    // 1 = odd, 0 = even
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 parity_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] LAST_D   = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_S   = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t               state, state_nxt;
    logic                 rx_meta, rx_s;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bidx;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] dout;
    logic                 ferr;
    logic                 armed;
    logic                 bit_tick, half_tick;

`ifdef UART_RX_PARITY_EN
    logic                 par_bit;
`else
    // PARITY_ODD has no meaning without the parity stage.
    logic                 unused_cfg;
    assign unused_cfg = ^PARITY_ODD;
`endif

    assign bit_tick  = (cnt == BIT_END);
    assign half_tick = (cnt == HALF_END);
    assign data_out  = dout;

    // Two-flop synchroniser; resets to the idle-high line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic: all decisions taken on the synchronised line.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (armed && !rx_s) state_nxt = START;
            // Half-bit check rejects glitches shorter than half a bit.
            START:  if (half_tick) state_nxt = rx_s ? IDLE : DATA;
            DATA: begin
                if (bit_tick && bidx == LAST_D) begin
`ifdef UART_RX_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (bit_tick) state_nxt = STOP;
`endif
            STOP:   if (bit_tick && bidx == LAST_S) state_nxt = DONE;
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: bit timing, shifting, flag capture and the break lockout.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            bidx  <= '0;
            shreg <= '0;
            dout  <= '0;
            ferr  <= 1'b0;
            armed <= 1'b1;
`ifdef UART_RX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    // A high line re-arms the receiver after a break.
                    if (rx_s) armed <= 1'b1;
                end
                START: begin
                    if (half_tick) begin
                        cnt  <= '0;
                        bidx <= '0;
                        ferr <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        cnt   <= '0;
                        // LSB arrives first, so shift in at the top.
                        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                        bidx  <= (bidx == LAST_D) ? '0 : bidx + BW'(1);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (bit_tick) begin
                        cnt     <= '0;
                        par_bit <= rx_s;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`endif
                STOP: begin
                    if (bit_tick) begin
                        cnt  <= '0;
                        bidx <= bidx + BW'(1);
                        if (!rx_s) ferr <= 1'b1;
                        // Publish the word as DONE is entered so data_out
                        // is already current during the valid pulse.
                        if (bidx == LAST_S) dout <= shreg;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    // A framing error may be a break: wait for a high line.
                    if (ferr) armed <= 1'b0;
                end
                default: cnt <= '0;
            endcase
        end
    end

    // Outputs: single-cycle pulses in DONE, busy outside IDLE.
    always_comb begin
        valid      = 1'b0;
        frame_err  = 1'b0;
        parity_err = 1'b0;
        busy       = (state != IDLE);
        if (state == DONE) begin
            valid     = 1'b1;
            frame_err = ferr;
`ifdef UART_RX_PARITY_EN
            parity_err = ((^shreg) ^ par_bit) != PARITY_ODD[0];
`endif
        end
    end

endmodule
